// File: rtl/phase_gen_pkg.sv
// Shared constants and state encoding for the
// phase-shifted square-wave generator.
package phase_gen_pkg;

    localparam int CNT_W      = 32;
    localparam int PHASE_W    = 9;
    localparam int PROD_W     = CNT_W + PHASE_W;
    localparam int DEG_FULL   = 360;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN
    } state_t;

endpackage

// File: rtl/seq_udiv.sv
// Restoring shift-subtract unsigned divider,
// one quotient bit per clock, PROD_W clocks per divide.
module seq_udiv
    import phase_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] dividend,
    input  logic [PHASE_W-1:0] divisor,
    output logic              done,
    output logic [PROD_W-1:0] quotient
);

    localparam int CW = $clog2(PROD_W + 1);

    logic [PHASE_W-1:0] r_rem;
    logic [PHASE_W-1:0] r_div;
    logic [PROD_W-1:0]  r_quo;
    logic [CW-1:0]      r_cnt;

    logic [PHASE_W:0]   w_shift;
    logic [PHASE_W:0]   w_diff;
    logic               w_ge;
    logic [PHASE_W-1:0] w_rem_nxt;
    logic [PROD_W-1:0]  w_quo_nxt;

    assign w_shift   = {r_rem, r_quo[PROD_W-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    // remainder always stays below the divisor, so it fits PHASE_W bits
    assign w_rem_nxt = PHASE_W'(w_ge ? w_diff : w_shift);
    assign w_quo_nxt = {r_quo[PROD_W-2:0], w_ge};

    // final step result is presented combinationally with done
    assign done      = (r_cnt == CW'(1));
    assign quotient  = w_quo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_div <= divisor;
            r_quo <= dividend;
            r_cnt <= CW'(PROD_W);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/phase_sig_gen.sv
// Dual-channel square-wave generator: sig_b trails
// sig_a by floor(P*phase/360) clock cycles.
module phase_sig_gen
    import phase_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [PHASE_W-1:0] cfg_phase,
    output logic               cfg_err,
    output logic               sig_a,
    output logic               sig_b,
    output logic               running
);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_d;
    logic [CNT_W-1:0] r_p_new;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_sig_a;
    logic             r_sig_b;
    logic             r_err;

    logic              w_fire;
    logic              w_bad;
    logic              w_accept;
    logic              w_reject;
    logic              w_enter;
    logic              w_use_new;
    logic              w_stay_run;
    logic              w_div_done;
    logic [PROD_W-1:0] w_product;
    logic [PROD_W-1:0] w_quo;
    logic [CNT_W-1:0]  w_d_new;
    logic [CNT_W-1:0]  w_p_eff;
    logic [CNT_W-1:0]  w_d_eff;
    logic [CNT_W-1:0]  w_cnt_b_init;
    logic [CNT_W-1:0]  w_half;
    logic [CNT_W-1:0]  w_cnt_a_nxt;
    logic [CNT_W-1:0]  w_cnt_b_nxt;

    assign cfg_ready = (r_state != CALC);
    assign running   = (r_state == RUN);
    assign cfg_err   = r_err;
    assign sig_a     = r_sig_a;
    assign sig_b     = r_sig_b;

    assign w_fire    = cfg_valid && cfg_ready;
    assign w_bad     = (cfg_period < CNT_W'(MIN_PERIOD))
                    || (cfg_phase >= PHASE_W'(DEG_FULL));
    assign w_product = PROD_W'(cfg_period) * PROD_W'(cfg_phase);

    seq_udiv u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept),
        .dividend (w_product),
        .divisor  (PHASE_W'(DEG_FULL)),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    // quotient < P always, so the upper product bits are zero
    assign w_d_new      = CNT_W'(w_quo);
    assign w_p_eff      = w_use_new ? r_p_new : r_p;
    assign w_d_eff      = w_use_new ? w_d_new : r_d;
    assign w_cnt_b_init = (w_d_eff == '0) ? '0 : w_p_eff - w_d_eff;

    assign w_half      = r_p >> 1;
    assign w_cnt_a_nxt = (r_cnt_a == r_p - 1'b1) ? '0 : r_cnt_a + 1'b1;
    assign w_cnt_b_nxt = (r_cnt_b == r_p - 1'b1) ? '0 : r_cnt_b + 1'b1;
    assign w_stay_run  = (r_state == RUN) && (w_state_nxt == RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_enter     = 1'b0;
        w_use_new   = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else if (w_fire && w_bad) begin
            w_reject = 1'b1;
        end else if (w_fire) begin
            w_accept    = 1'b1;
            w_state_nxt = CALC;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_p >= CNT_W'(MIN_PERIOD)) begin
                        w_state_nxt = RUN;
                        w_enter     = 1'b1;
                    end
                end
                CALC: begin
                    if (w_div_done) begin
                        w_state_nxt = RUN;
                        w_enter     = 1'b1;
                        w_use_new   = 1'b1;
                    end
                end
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_d     <= '0;
            r_p_new <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_sig_a <= 1'b0;
            r_sig_b <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_reject;
            r_sig_a <= w_stay_run && (r_cnt_a < w_half);
            r_sig_b <= w_stay_run && (r_cnt_b < w_half);
            if (w_accept) begin
                r_p_new <= cfg_period;
            end
            if (w_use_new) begin
                r_p <= r_p_new;
                r_d <= w_d_new;
            end
            if (w_enter) begin
                r_cnt_a <= '0;
                r_cnt_b <= w_cnt_b_init;
            end else if (w_stay_run) begin
                r_cnt_a <= w_cnt_a_nxt;
                r_cnt_b <= w_cnt_b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_phase_sig_gen.sv
// Directed bench for phase_sig_gen: vector table for
// waveform shape and lag, plus hand-written corner sequences.
module tb_phase_sig_gen;

    localparam int CALC_LEN = 41;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic [8:0]  cfg_phase;
    logic        cfg_err;
    logic        sig_a;
    logic        sig_b;
    logic        running;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int p;
        int ph;
        int h;
        int l;
        int d;
    } vec_t;

    vec_t vecs[7];

    phase_sig_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .sig_a      (sig_a),
        .sig_b      (sig_b),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic do_cfg(int p, int ph, string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        cfg_period = p;
        cfg_phase  = ph[8:0];
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        while (running !== 1'b1 && n < 200) begin
            if (sig_a !== 1'b0 || sig_b !== 1'b0 || cfg_ready !== 1'b0)
                bad++;
            tick();
            n++;
        end
        check({tag, "_calc_len"}, n, CALC_LEN);
        check({tag, "_calc_quiet"}, bad, 0);
    endtask

    task automatic model_wave(int p, int d, int ncyc, bit inject, string tag);
        int   h;
        int   bad;
        logic ea;
        logic eb;
        h   = p / 2;
        bad = 0;
        for (int t = 1; t <= ncyc; t++) begin
            if (inject && t == 31) begin
                cfg_period = 1;
                cfg_phase  = 0;
                cfg_valid  = 1'b1;
            end
            if (inject && t == 61) begin
                cfg_period = 100;
                cfg_phase  = 9'd360;
                cfg_valid  = 1'b1;
            end
            tick();
            cfg_valid = 1'b0;
            ea = (((t - 1) % p) < h);
            eb = (((t - 1 + p - d) % p) < h);
            if (sig_a !== ea || sig_b !== eb || running !== 1'b1)
                bad++;
            if (inject && t == 31)
                check({tag, "_err_period"}, cfg_err, 1);
            if (inject && t == 32)
                check({tag, "_err_pulse"}, cfg_err, 0);
            if (inject && t == 61)
                check({tag, "_err_phase"}, cfg_err, 1);
        end
        check({tag, "_wave"}, bad, 0);
    endtask

    task automatic run_vec(vec_t v, string tag);
        int   ra[$];
        int   fa[$];
        int   rb[$];
        logic pa;
        logic pb;
        int   diff;
        int   nrun;
        int   lag;
        do_cfg(v.p, v.ph, tag);
        pa   = 1'b0;
        pb   = 1'b0;
        diff = 0;
        nrun = 0;
        lag  = -1;
        for (int t = 1; t <= 3 * v.p + 2; t++) begin
            tick();
            if (running !== 1'b1) nrun++;
            if (sig_a && !pa) ra.push_back(t);
            if (!sig_a && pa) fa.push_back(t);
            if (sig_b && !pb) rb.push_back(t);
            if (sig_a !== sig_b) diff++;
            pa = sig_a;
            pb = sig_b;
        end
        check({tag, "_running"}, nrun, 0);
        check({tag, "_edges"}, (ra.size() >= 2 && fa.size() >= 1), 1);
        if (ra.size() >= 2 && fa.size() >= 1) begin
            check({tag, "_first_rise"}, ra[0], 1);
            check({tag, "_high"}, fa[0] - ra[0], v.h);
            check({tag, "_low"}, ra[1] - fa[0], v.l);
            foreach (rb[k])
                if (lag < 0 && rb[k] >= ra[1] && rb[k] < ra[1] + v.p)
                    lag = rb[k] - ra[1];
            check({tag, "_lag"}, lag, v.d);
        end
        if (v.ph == 0)
            check({tag, "_identical"}, diff, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{p: 100, ph: 90,  h: 50,  l: 50,  d: 25};
        vecs[1] = '{p: 7,   ph: 180, h: 3,   l: 4,   d: 3};
        vecs[2] = '{p: 360, ph: 359, h: 180, l: 180, d: 359};
        vecs[3] = '{p: 360, ph: 0,   h: 180, l: 180, d: 0};
        vecs[4] = '{p: 10,  ph: 45,  h: 5,   l: 5,   d: 1};
        vecs[5] = '{p: 2,   ph: 359, h: 1,   l: 1,   d: 1};
        vecs[6] = '{p: 3,   ph: 120, h: 1,   l: 2,   d: 1};

        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_phase  = '0;
        tick();
        tick();
        check("rst_sig_a", sig_a, 0);
        check("rst_sig_b", sig_b, 0);
        check("rst_running", running, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        en = 1'b1;
        tick();
        tick();
        tick();
        check("idle_no_cfg", running, 0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        do_cfg(100, 90, "rej");
        model_wave(100, 25, 150, 1'b1, "rej");

        en = 1'b0;
        tick();
        check("en_off_sig_a", sig_a, 0);
        check("en_off_sig_b", sig_b, 0);
        check("en_off_running", running, 0);
        check("en_off_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        check("resume_running", running, 1);
        check("resume_err", cfg_err, 0);
        model_wave(100, 25, 120, 1'b0, "resume");

        cfg_period = 7;
        cfg_phase  = 180;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0;
        tick();
        check("abort_running", running, 0);
        check("abort_ready", cfg_ready, 1);
        check("abort_sig", {sig_a, sig_b}, 0);
        en = 1'b1;
        tick();
        check("abort_resume", running, 1);
        model_wave(100, 25, 120, 1'b0, "keep_old");

        en         = 1'b0;
        cfg_period = 20;
        cfg_phase  = 90;
        cfg_valid  = 1'b1;
        tick();
        check("drop_err", cfg_err, 0);
        check("drop_ready", cfg_ready, 1);
        check("drop_running", running, 0);
        cfg_period = 1;
        tick();
        check("drop_bad_err", cfg_err, 0);
        cfg_valid = 1'b0;
        en = 1'b1;
        tick();
        check("drop_resume", running, 1);
        model_wave(100, 25, 120, 1'b0, "dropped");

        cfg_period = 7;
        cfg_phase  = 180;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        check("rst_calc_sig", {sig_a, sig_b}, 0);
        check("rst_calc_running", running, 0);
        check("rst_calc_ready", cfg_ready, 1);
        check("rst_calc_err", cfg_err, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("rst_calc_idle", running, 0);
        check("rst_calc_noerr", cfg_err, 0);

        do_cfg(7, 180, "post_rst");
        model_wave(7, 3, 30, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
